// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
// One-cycle request pulse with address; the memory answers later with rvalid/rdata.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over the
// imem bus, presents the IR and its decode fields until the core acknowledges it,
// then advances the PC from PCSrc / pc_target.
//
// state | meaning
// FETCH | issue a one-cycle imem_req at pc (first cycle after reset arms the request)
// WAIT  | waiting for imem_rvalid, counting cycles toward the timeout
// HOLD  | IR valid for decode, waiting for instr_ack
// ERR   | terminal error (misaligned target or timeout); leave only by reset
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic                      instr_valid,
    input  logic                      instr_ack,
    input  logic                      PCSrc,
    input  logic [31:0]               pc_target,
    output logic [31:0]               instr,
    output logic [6:0]                op,
    output logic [2:0]                funct3,
    output logic                      funct7b5,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic [1:0]                fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // The counter holds the number of WAIT cycles already spent without rvalid,
    // so the last permitted WAIT cycle is the one where it reads TIMEOUT_CYC-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       req_q;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // Decode fields and sequential PC are pure slices/sums of registers.
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign pc_plus4 = pc + 32'd4;

    // Fetch sequencer: state, PC, IR, request pulse, valid flag and sticky error.
    // imem_req is set one edge ahead so it is high exactly during the FETCH cycle;
    // after reset FETCH spends one extra cycle arming the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            req_q       <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 2'b00;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                FETCH: begin
                    wait_cnt <= 8'd0;
                    if (req_q) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                WAIT: begin
                    req_q <= 1'b0;
                    if (imem.imem_rvalid) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fetch_err <= 2'b10;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        if (!PCSrc) begin
                            pc    <= pc_plus4;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end else if (pc_target[1:0] == 2'b00) begin
                            pc    <= pc_target;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end else begin
                            fetch_err <= 2'b01;
                            state     <= ERR;
                        end
                    end
                end
                default: begin
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
